// File: rtl/ntt_addr_gen.sv
// Purpose: sequences the 7 Kyber NTT/INTT layers and generates twiddle ROM and coefficient address pairs.
// Latency: start -> zeta_addr next cycle -> bf_* the cycle after, aligned with registered ROM data.
// Backpressure: none; one butterfly issued per RUN cycle, with LAYER_GAP bubbles between layers.
module ntt_addr_gen #(
    parameter int LAYER_GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic [6:0] zeta_addr,
    output logic       bf_valid,
    output logic [7:0] bf_addr_a,
    output logic [7:0] bf_addr_b,
    output logic [2:0] bf_layer,
    output logic       bf_last
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    // Terminal count of the bubble counter; unused when LAYER_GAP is 0.
    localparam logic [3:0] GAP_LAST = 4'(LAYER_GAP - 1);

    state_t     state, state_nxt;
    logic [2:0] layer, layer_nxt;
    logic [6:0] idx, idx_nxt;
    logic [3:0] gap_cnt, gap_nxt;
    logic       inv_q, inv_nxt;
    logic       issue;
    logic       done_nxt;

    // Issue arithmetic signals
    logic       mode;
    logic [2:0] sh;
    logic [7:0] i8, len8, g8, a8, b8, k8;
    logic [6:0] zeta_c;
    logic       last_c;

    // Delay stage between the zeta_addr edge and the bf_* edge
    logic       vld_d;
    logic       last_d;
    logic [7:0] a_d, b_d;
    logic [2:0] layer_d;

    assign busy = (state != IDLE);

    // Next-state, counter and issue decisions; defaults hold everything.
    always_comb begin
        state_nxt = state;
        layer_nxt = layer;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        inv_nxt   = inv_q;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                // The cycle done is high still reads as IDLE; a start there is dropped.
                if (start && !done) begin
                    inv_nxt   = inv;
                    state_nxt = RUN;
                    issue     = 1'b1;
                end
            end
            RUN: begin
                issue = 1'b1;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = RUN;
                    gap_nxt   = 4'd0;
                end else begin
                    gap_nxt = gap_cnt + 4'd1;
                end
            end
            DONE: begin
                // Two cycles let the final butterfly leave the delay stage before done.
                if (gap_cnt == 4'd1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    layer_nxt = 3'd0;
                    gap_nxt   = 4'd0;
                end else begin
                    gap_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            if (idx == 7'd127) begin
                idx_nxt = 7'd0;
                gap_nxt = 4'd0;
                if (layer == 3'd6) begin
                    state_nxt = DONE;
                end else begin
                    layer_nxt = layer + 3'd1;
                    state_nxt = (LAYER_GAP == 0) ? RUN : GAP;
                end
            end else begin
                idx_nxt = idx + 7'd1;
            end
        end
    end

    // Butterfly index/twiddle arithmetic for the (layer, idx) being issued now.
    always_comb begin
        // In IDLE the mode register is not yet loaded, so use the live input.
        mode = (state == IDLE) ? inv : inv_q;
        sh   = mode ? (layer + 3'd1) : (3'd7 - layer);
        i8   = {1'b0, idx};
        len8 = 8'd1 << sh;
        g8   = i8 >> sh;
        // 2*g*len + o equals i + g*len since i = g*len + o.
        a8   = i8 + (g8 << sh);
        b8   = a8 + len8;
        k8   = mode ? ((8'd1 << (3'd7 - layer)) - 8'd1 - g8)
                    : ((8'd1 << layer) + g8);
        for (int j = 0; j < 7; j++) begin
            zeta_c[j] = k8[6-j];
        end
        last_c = (layer == 3'd6) && (idx == 7'd127);
    end

    // State, counters, ROM address, delay stage and aligned butterfly outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            layer     <= 3'd0;
            idx       <= 7'd0;
            gap_cnt   <= 4'd0;
            inv_q     <= 1'b0;
            done      <= 1'b0;
            zeta_addr <= 7'd0;
            vld_d     <= 1'b0;
            last_d    <= 1'b0;
            a_d       <= 8'd0;
            b_d       <= 8'd0;
            layer_d   <= 3'd0;
            bf_valid  <= 1'b0;
            bf_last   <= 1'b0;
            bf_addr_a <= 8'd0;
            bf_addr_b <= 8'd0;
            bf_layer  <= 3'd0;
        end else begin
            state   <= state_nxt;
            layer   <= layer_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
            inv_q   <= inv_nxt;
            done    <= done_nxt;
            vld_d   <= issue;
            last_d  <= issue && last_c;
            if (issue) begin
                zeta_addr <= zeta_c;
                a_d       <= a8;
                b_d       <= b8;
                layer_d   <= layer;
            end
            bf_valid <= vld_d;
            bf_last  <= vld_d && last_d;
            if (vld_d) begin
                bf_addr_a <= a_d;
                bf_addr_b <= b_d;
                bf_layer  <= layer_d;
            end
        end
    end

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Purpose: checks ntt_addr_gen (LAYER_GAP 4 and 0) against a loop-nest model of the Kyber NTT/INTT order.
// Latency: expects zeta one cycle after start, bf_* two cycles after, done after the last butterfly.
// Backpressure: none in the design; the bench only observes.
module tb_ntt_addr_gen;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] layer;
        logic [6:0] zeta;
        logic       last;
    } bf_t;

    logic clk;
    logic rst4_n, start4, inv4, busy4, done4, bf_valid4, bf_last4;
    logic [6:0] zeta4;
    logic [7:0] a4, b4;
    logic [2:0] layer4;
    logic rst0_n, start0, inv0, busy0, done0, bf_valid0, bf_last0;
    logic [6:0] zeta0;
    logic [7:0] a0, b0;
    logic [2:0] layer0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bf_t q4[$];
    bf_t q0[$];
    bf_t e4, e0;
    int  gap_q[$];
    int  nv4, zrun4, first_v4, last_v4, ndone4;
    int  nv0, zrun0, last_v0, gaps0;
    int  idx0[256];
    logic [6:0] zp4, zp0;

    ntt_addr_gen #(.LAYER_GAP(4)) u_dut (
        .clk(clk), .rst_n(rst4_n), .start(start4), .inv(inv4),
        .busy(busy4), .done(done4), .zeta_addr(zeta4), .bf_valid(bf_valid4),
        .bf_addr_a(a4), .bf_addr_b(b4), .bf_layer(layer4), .bf_last(bf_last4)
    );

    ntt_addr_gen #(.LAYER_GAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .start(start0), .inv(inv0),
        .busy(busy0), .done(done0), .zeta_addr(zeta0), .bf_valid(bf_valid0),
        .bf_addr_a(a0), .bf_addr_b(b0), .bf_layer(layer0), .bf_last(bf_last0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [6:0] brev(input logic [6:0] k);
        logic [6:0] r;
        for (int j = 0; j < 7; j++) r[j] = k[6-j];
        return r;
    endfunction

    // Reference order: Kyber loop nest, one zeta index per group.
    task automatic push_model(input bit inv_m, input bit to0);
        bf_t e;
        int  k, n, len;
        n = 0;
        k = inv_m ? 127 : 1;
        for (int l = 0; l < 7; l++) begin
            len = inv_m ? (2 << l) : (128 >> l);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) begin
                    e.a     = 8'(j);
                    e.b     = 8'(j + len);
                    e.layer = 3'(l);
                    e.zeta  = brev(7'(k));
                    e.last  = (n == 895);
                    n++;
                    if (to0) q0.push_back(e);
                    else     q4.push_back(e);
                end
                k = inv_m ? k - 1 : k + 1;
            end
        end
    endtask

    task automatic clear4();
        nv4 = 0; zrun4 = 0; first_v4 = -1; last_v4 = -1;
        gap_q.delete();
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the LAYER_GAP=4 instance; zeta_addr is compared one cycle late.
    always @(negedge clk) begin
        if (bf_valid4) begin
            if (zrun4 > 0 && nv4 > 0) gap_q.push_back(zrun4);
            zrun4 = 0;
            nv4++;
            last_v4 = cyc;
            if (nv4 == 1) first_v4 = cyc;
            if (q4.size() == 0) begin
                chk("bf4_unexpected", 32'(q4.size()), 32'd1);
            end else begin
                e4 = q4.pop_front();
                chk($sformatf("bf4_%0d", nv4 - 1), 32'({a4, b4, layer4, zp4, bf_last4}), 32'(e4));
            end
        end else if (nv4 > 0) begin
            zrun4++;
        end
        if (done4) ndone4++;
        zp4 = zeta4;
    end

    // Scoreboard and coverage counters for the LAYER_GAP=0 instance.
    always @(negedge clk) begin
        if (bf_valid0) begin
            if (zrun0 > 0 && nv0 > 0) gaps0++;
            zrun0 = 0;
            nv0++;
            last_v0 = cyc;
            if (q0.size() == 0) begin
                chk("bf0_unexpected", 32'(q0.size()), 32'd1);
            end else begin
                e0 = q0.pop_front();
                chk($sformatf("bf0_%0d", nv0 - 1), 32'({a0, b0, layer0, zp0, bf_last0}), 32'(e0));
            end
            idx0[a0]++;
            idx0[b0]++;
        end else if (nv0 > 0) begin
            zrun0++;
        end
        zp0 = zeta0;
    end

    initial begin
        int c0, d4, d0, s1, s2, nd, t, bad;
        rst4_n = 0; rst0_n = 0; start4 = 0; inv4 = 0; start0 = 0; inv0 = 0;
        ndone4 = 0; nv0 = 0; zrun0 = 0; last_v0 = -1; gaps0 = 0;
        for (int j = 0; j < 256; j++) idx0[j] = 0;
        clear4();
        repeat (3) next_cyc();
        chk("reset_outs4", 32'({busy4, done4, bf_valid4, bf_last4, zeta4, a4, b4, layer4}), 32'd0);
        chk("reset_outs0", 32'({busy0, done0, bf_valid0, bf_last0, zeta0, a0, b0, layer0}), 32'd0);
        rst4_n = 1; rst0_n = 1;
        repeat (2) next_cyc();

        // Forward on both instances, with a stray start mid-run on the gapped one.
        push_model(1'b0, 1'b0);
        push_model(1'b0, 1'b1);
        start4 = 1; inv4 = 0; start0 = 1; inv0 = 0;
        c0 = cyc;
        chk("busy_idle", 32'(busy4), 32'd0);
        next_cyc();
        start4 = 0; start0 = 0;
        chk("zeta_first", 32'(zeta4), 32'd64);
        chk("busy_c1", 32'(busy4), 32'd1);
        chk("valid_c1", 32'(bf_valid4), 32'd0);
        next_cyc();
        chk("valid_c2", 32'(bf_valid4), 32'd1);
        while (cyc < c0 + 100) next_cyc();
        start4 = 1; inv4 = 1;
        next_cyc();
        start4 = 0; inv4 = 0;
        t = 0; d0 = -1;
        while (!done4 && t < 1500) begin
            if (done0 && d0 < 0) d0 = cyc;
            next_cyc();
            t++;
        end
        d4 = cyc;
        chk("done4_cycle", 32'(d4 - c0), 32'd922);
        chk("first_valid4", 32'(first_v4 - c0), 32'd2);
        chk("last_valid4", 32'(last_v4 - c0), 32'd921);
        chk("count4", 32'(nv4), 32'd896);
        chk("busy_at_done", 32'(busy4), 32'd0);
        chk("queue4_empty", 32'(q4.size()), 32'd0);
        chk("gap_count", 32'(gap_q.size()), 32'd6);
        foreach (gap_q[j]) chk($sformatf("gap_len_%0d", j), 32'(gap_q[j]), 32'd4);
        chk("done0_cycle", 32'(d0 - c0), 32'd898);
        chk("last_valid0", 32'(last_v0 - c0), 32'd897);
        chk("count0", 32'(nv0), 32'd896);
        chk("gaps0", 32'(gaps0), 32'd0);
        chk("queue0_empty", 32'(q0.size()), 32'd0);
        bad = 0;
        for (int j = 0; j < 256; j++) if (idx0[j] != 7) bad++;
        chk("idx_seen_7x", 32'(bad), 32'd0);

        // start in the done cycle is dropped; start the next cycle runs an inverse transform.
        start4 = 1; inv4 = 1;
        next_cyc();
        chk("start_in_done_ignored", 32'(busy4), 32'd0);
        clear4();
        push_model(1'b1, 1'b0);
        s1 = cyc;
        next_cyc();
        start4 = 0; inv4 = 0;
        chk("busy_after_restart", 32'(busy4), 32'd1);
        t = 0;
        while (!done4 && t < 1500) begin next_cyc(); t++; end
        chk("done_inv_cycle", 32'(cyc - s1), 32'd922);
        chk("count_inv", 32'(nv4), 32'd896);
        chk("queue_inv_empty", 32'(q4.size()), 32'd0);

        // Reset mid-run, then a clean forward transform.
        repeat (3) next_cyc();
        clear4();
        push_model(1'b0, 1'b0);
        start4 = 1; inv4 = 0;
        s2 = cyc;
        next_cyc();
        start4 = 0;
        while (cyc < s2 + 300) next_cyc();
        rst4_n = 0;
        nd = ndone4;
        next_cyc();
        q4.delete();
        chk("midrun_reset_outs", 32'({busy4, done4, bf_valid4, bf_last4, zeta4, a4, b4, layer4}), 32'd0);
        next_cyc();
        rst4_n = 1;
        repeat (20) next_cyc();
        chk("no_done_after_reset", 32'(ndone4), 32'(nd));
        chk("idle_after_reset", 32'(busy4), 32'd0);
        clear4();
        push_model(1'b0, 1'b0);
        start4 = 1; inv4 = 0;
        s2 = cyc;
        next_cyc();
        start4 = 0;
        t = 0;
        while (!done4 && t < 1500) begin next_cyc(); t++; end
        chk("done_post_reset", 32'(cyc - s2), 32'd922);
        chk("count_post_reset", 32'(nv4), 32'd896);
        chk("queue_post_reset", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
